// File: rtl/fir_sample_feeder_if.sv
// Bus between fir_sample_feeder and its neighbours: the acquisition-side
// sample handshake, the coefficient write port and FIR_TOP's read port.
// The master side drives requests; the feeder takes the slave side.
interface fir_sample_feeder_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int H_ADDR_WIDTH = 4,
    parameter int X_ADDR_WIDTH = 6
);
    // acquisition-side sample handshake
    logic                    s_valid;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_ready;

    // coefficient write port
    logic                    coef_we;
    logic [H_ADDR_WIDTH-1:0] coef_addr;
    logic [DATA_WIDTH-1:0]   coef_data;

    // FIR_TOP read port
    logic                    R_en;
    logic [H_ADDR_WIDTH-1:0] h_addr;
    logic [X_ADDR_WIDTH-1:0] x_addr;
    logic [DATA_WIDTH-1:0]   x_i;
    logic [DATA_WIDTH-1:0]   h_i;

    // status
    logic                    start_o;
    logic [X_ADDR_WIDTH:0]   fill_cnt;

    modport master (
        output s_valid, s_data, coef_we, coef_addr, coef_data, R_en, h_addr, x_addr,
        input  s_ready, x_i, h_i, start_o, fill_cnt
    );

    modport slave (
        input  s_valid, s_data, coef_we, coef_addr, coef_data, R_en, h_addr, x_addr,
        output s_ready, x_i, h_i, start_o, fill_cnt
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// Sample/coefficient feeder in front of FIR_TOP. Keeps the most recent
// samples in a circular buffer addressed by age (0 = newest), holds the tap
// coefficients in a writable RAM, answers reads with one cycle of latency and
// pulses start_o once for every sample it commits.
module fir_sample_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int H_ADDR_WIDTH = 4,
    parameter int X_ADDR_WIDTH = 6
) (
    input logic                clk,
    input logic                rst_n,
    fir_sample_feeder_if.slave bus
);
    localparam int X_DEPTH = 2 ** X_ADDR_WIDTH;
    localparam int H_DEPTH = 2 ** H_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]   x_mem [X_DEPTH];
    logic [DATA_WIDTH-1:0]   h_mem [H_DEPTH];

    logic                    run_q;     // set on the first edge after reset release
    logic [X_ADDR_WIDTH-1:0] wr_ptr;    // slot the next sample goes into
    logic [X_ADDR_WIDTH:0]   fill_q;
    logic                    start_q;
    logic [DATA_WIDTH-1:0]   x_q;
    logic [DATA_WIDTH-1:0]   h_q;

    logic                    ready;
    logic                    xfer;
    logic [X_ADDR_WIDTH-1:0] rd_idx;
    logic                    x_pad;

    // History is frozen while FIR_TOP walks a window, so refuse samples then.
    assign ready  = run_q & ~bus.R_en;
    assign xfer   = bus.s_valid & ready;

    // Age m lives m slots behind the newest entry; the subtraction wraps mod depth.
    assign rd_idx = wr_ptr - X_ADDR_WIDTH'(1) - bus.x_addr;
    // Ages we have not collected yet read as zero.
    assign x_pad  = ({1'b0, bus.x_addr} >= fill_q);

    assign bus.s_ready  = ready;
    assign bus.start_o  = start_q;
    assign bus.fill_cnt = fill_q;
    assign bus.x_i      = x_q;
    assign bus.h_i      = h_q;

    // Write pointer, fill level and the commit pulse advance on each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            wr_ptr  <= '0;
            fill_q  <= '0;
            start_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            run_q   <= 1'b1;
            start_q <= xfer;
            if (xfer) begin
                wr_ptr <= wr_ptr + X_ADDR_WIDTH'(1);
                // The top bit is set only at exactly full, so it doubles as the saturation flag.
                if (!fill_q[X_ADDR_WIDTH]) begin
                    fill_q <= fill_q + (X_ADDR_WIDTH+1)'(1);
                end
            end
        end
    end

    // Sample buffer write; xfer is already forced low during reset.
    // NOTE: the RAM arrays carry no reset -- their contents are meaningless
    // until written, and fill_q hides stale samples from readers.
    always_ff @(posedge clk) begin
        if (xfer) begin
            x_mem[wr_ptr] <= bus.s_data;
        end
    end

    // Coefficient write, usable at any time except while reset is held.
    always_ff @(posedge clk) begin
        if (bus.coef_we && rst_n) begin
            h_mem[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Registered read port; a same-address coefficient write shows up on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            h_q <= '0;
        end else if (bus.R_en) begin
            x_q <= x_pad ? '0 : x_mem[rd_idx];
            h_q <= h_mem[bus.h_addr];
        end
    end
endmodule
